// File: rtl/border_tiler_if.sv
// Pixel-side bus of border_tiler: sync-counter inputs, run-time animation controls,
// and the registered tile-ROM address/side outputs.
interface border_tiler_if #(
    parameter int ADDR_W = 10
);
    logic              active;
    logic [10:0]       p_x;
    logic [9:0]        p_y;
    logic [1:0]        mode;
    logic [3:0]        speed;
    logic              enable;
    logic [ADDR_W-1:0] address;
    logic [1:0]        side;
    logic              frame_tick;

    modport master (
        output active, p_x, p_y, mode, speed,
        input  enable, address, side, frame_tick
    );

    modport slave (
        input  active, p_x, p_y, mode, speed,
        output enable, address, side, frame_tick
    );
endinterface

// File: rtl/border_tiler.sv
// Screen-border tile decoder: maps a VGA pixel to a border tile address and side,
// with frame-synchronous clockwise scroll and blink animation.
module border_tiler #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int BLOCK    = 25,
    parameter int THICK    = 1,
    parameter int ADDR_W   = 10
) (
    input logic           clk,
    input logic           reset,
    border_tiler_if.slave bus
);
    localparam int SW = (BLOCK > 1) ? $clog2(BLOCK) : 1;
    localparam int W  = BLOCK * THICK;

    // All coordinate arithmetic is done in 13 bits: wide enough for p_x + BLOCK.
    localparam logic [12:0] B13  = 13'(BLOCK);
    localparam logic [12:0] W13  = 13'(W);
    localparam logic [12:0] HW13 = 13'(H_ACTIVE - W);
    localparam logic [12:0] VW13 = 13'(V_ACTIVE - W);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SIDE_TOP    = 2'd0,
        SIDE_RIGHT  = 2'd1,
        SIDE_BOTTOM = 2'd2,
        SIDE_LEFT   = 2'd3
    } side_e;

    mode_e             mode_q, mode_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic              phase_q, phase_d;
    logic              enable_q, enable_d;
    logic [ADDR_W-1:0] address_q, address_d;
    side_e             side_q, side_d;
    logic              tick_q, tick_d;

    logic [12:0]   x13, y13, s13;
    logic [SW-1:0] row, col;
    logic          hit, blanked, frame_start;
    side_e         region;

    // Constant-divisor modulo; every caller passes a non-negative operand so the
    // result never wraps to a huge value.
    function automatic logic [SW-1:0] mod_b(input logic [12:0] v);
        logic [12:0] r;
        r = v % B13;
        return r[SW-1:0];
    endfunction

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        x13    = {2'b00, bus.p_x};
        y13    = {3'b000, bus.p_y};
        s13    = (mode_q == MODE_SCROLL) ? 13'(shift_q) : 13'd0;
        hit    = 1'b0;
        region = SIDE_TOP;
        row    = '0;
        col    = '0;
        if (bus.active) begin
            if (y13 < W13) begin
                hit    = 1'b1;
                region = SIDE_TOP;
                row    = mod_b(y13);
                col    = mod_b(x13 + B13 - s13);
            end else if (y13 >= VW13) begin
                hit    = 1'b1;
                region = SIDE_BOTTOM;
                row    = mod_b(y13 - VW13);
                col    = mod_b(x13 + s13);
            end else if (x13 >= HW13) begin
                hit    = 1'b1;
                region = SIDE_RIGHT;
                row    = mod_b(y13 - W13 + B13 - s13);
                col    = mod_b(x13 - HW13);
            end else if (x13 < W13) begin
                hit    = 1'b1;
                region = SIDE_LEFT;
                row    = mod_b(y13 - W13 + s13);
                col    = mod_b(x13);
            end
        end
        blanked   = (mode_q == MODE_BLINK) && !phase_q;
        enable_d  = hit && !blanked;
        side_d    = enable_d ? region : SIDE_TOP;
        address_d = enable_d ? (ADDR_W'(row) * ADDR_W'(BLOCK) + ADDR_W'(col)) : '0;
    end

    // Animation state advances only at frame start, so a frame is never torn.
    always_comb begin
        frame_start = (bus.p_x == 11'd0) && (bus.p_y == 10'd0);
        tick_d      = frame_start;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        phase_d     = phase_q;
        if (frame_start) begin
            mode_d = mode_e'(bus.mode);
            if (mode_d != mode_q) begin
                cnt_d   = 4'd0;
                phase_d = 1'b1;
            end else if (cnt_q == bus.speed) begin
                cnt_d = 4'd0;
                case (mode_q)
                    MODE_SCROLL: shift_d = (shift_q == SW'(BLOCK - 1)) ? '0 : shift_q + SW'(1);
                    MODE_BLINK:  phase_d = ~phase_q;
                    default:     ;
                endcase
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= MODE_STATIC;
            cnt_q     <= 4'd0;
            shift_q   <= '0;
            phase_q   <= 1'b1;
            enable_q  <= 1'b0;
            address_q <= '0;
            side_q    <= SIDE_TOP;
            tick_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            phase_q   <= phase_d;
            enable_q  <= enable_d;
            address_q <= address_d;
            side_q    <= side_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.enable     = enable_q;
    assign bus.address    = address_q;
    assign bus.side       = side_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_border_tiler.sv
// Directed bench for border_tiler: stimulus pushes hand-computed expectations into a
// queue, and a monitor compares them against the registered outputs one cycle later.
module tb_border_tiler;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic reset;

    border_tiler_if #(.ADDR_W(ADDR_W)) bus ();

    border_tiler #(
        .H_ACTIVE(800),
        .V_ACTIVE(600),
        .BLOCK   (25),
        .THICK   (1),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              tick;
        logic              en;
        logic [1:0]        side;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    logic [1:0] cur_mode  = 2'd0;
    logic [3:0] cur_speed = 4'd0;

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got tick=%0b en=%0b side=%0d addr=%0d, want tick=%0b en=%0b side=%0d addr=%0d",
                     name, act[13], act[12], act[11:10], act[9:0],
                     req[13], req[12], req[11:10], req[9:0]);
        end
    endtask

    // One vector per cycle; its result is checked at the negedge after the sampling edge.
    task automatic drive(input string name, input logic act, input int x, input int y,
                         input logic en, input int sd, input int addr);
        exp_t e;
        @(negedge clk);
        #1;
        bus.active = act;
        bus.p_x    = 11'(x);
        bus.p_y    = 10'(y);
        bus.mode   = cur_mode;
        bus.speed  = cur_speed;
        e.name = name;
        e.tick = (x == 0) && (y == 0);
        e.en   = en;
        e.side = 2'(sd);
        e.addr = ADDR_W'(addr);
        exp_q.push_back(e);
    endtask

    task automatic px(input string name, input int x, input int y,
                      input logic en, input int sd, input int addr);
        drive(name, 1'b1, x, y, en, sd, addr);
    endtask

    task automatic fs(input string name);
        drive(name, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check(mon_e.name,
                      {bus.frame_tick, bus.enable, bus.side, bus.address},
                      {mon_e.tick, mon_e.en, mon_e.side, mon_e.addr});
            end
        end
    end

    initial begin
        reset      = 1'b0;
        bus.active = 1'b0;
        bus.p_x    = 11'd400;
        bus.p_y    = 10'd300;
        bus.mode   = 2'd0;
        bus.speed  = 4'd0;
        #3;
        check("reset_state", {bus.frame_tick, bus.enable, bus.side, bus.address}, 14'd0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Static decode, corners and region boundaries
        fs("static_fs");
        px("top",          30,   3, 1'b1, 0,  80);
        px("bottom",       10, 580, 1'b1, 2, 135);
        px("left",          4,  40, 1'b1, 3, 379);
        px("right",       780,  60, 1'b1, 1, 255);
        px("centre",      400, 300, 1'b0, 0,   0);
        drive("inactive", 1'b0, 30, 3, 1'b0, 0, 0);
        px("corner_tr",   790,  10, 1'b1, 0, 265);
        px("corner_bl",     5, 590, 1'b1, 2, 380);
        px("top_max",      24,  24, 1'b1, 0, 624);
        px("inner_tl",     25,  25, 1'b0, 0,   0);
        px("corner_br",   775, 599, 1'b1, 2, 600);
        px("inner_br",    774, 574, 1'b0, 0,   0);
        px("right_last",  775, 574, 1'b1, 1, 600);
        px("unclamped",  1000, 700, 1'b1, 2,   0);

        // Mode change mid-frame has no effect until the next frame start
        cur_mode = 2'd1;
        px("midframe_left", 4, 100, 1'b1, 3, 4);
        px("midframe_top", 30,   3, 1'b1, 0, 80);

        // Scroll, speed 0: latching frame start does not step, each later one does
        fs("scroll_latch");
        px("scroll_s0", 30, 3, 1'b1, 0, 80);
        fs("scroll_fs1");
        px("scroll_s1", 30, 3, 1'b1, 0, 79);
        fs("scroll_fs2");
        fs("scroll_fs3");
        px("scroll_s3_top",     30,   3, 1'b1, 0,  77);
        px("scroll_s3_bottom",  10, 580, 1'b1, 2, 138);
        px("scroll_s3_right",  780,  60, 1'b1, 1, 180);
        px("scroll_s3_left",     4,  40, 1'b1, 3, 454);
        px("scroll_s3_topwrap",  1,   0, 1'b1, 0,  23);
        px("scroll_s3_rwrap",  775,  25, 1'b1, 1, 550);
        for (int i = 0; i < 21; i++) fs("scroll_fs_loop");
        px("scroll_s24", 30, 3, 1'b1, 0, 81);
        fs("scroll_fs25");
        px("scroll_wrap", 30, 3, 1'b1, 0, 80);

        // Blink, speed 1: on for frames 0-1, off for 2-3, on again at 4
        cur_mode  = 2'd2;
        cur_speed = 4'd1;
        fs("blink_f0");
        px("blink_f0_on", 30, 3, 1'b1, 0, 80);
        fs("blink_f1");
        px("blink_f1_on", 30, 3, 1'b1, 0, 80);
        fs("blink_f2");
        px("blink_f2_off",       30,  3, 1'b0, 0, 0);
        px("blink_f2_off_right", 780, 60, 1'b0, 0, 0);
        fs("blink_f3");
        px("blink_f3_off", 30, 3, 1'b0, 0, 0);
        fs("blink_f4");
        px("blink_f4_on", 30, 3, 1'b1, 0, 80);

        // Build up a non-zero shift, then reset asynchronously mid-frame
        cur_mode  = 2'd1;
        cur_speed = 4'd0;
        fs("pre_reset_latch");
        fs("pre_reset_fs1");
        fs("pre_reset_fs2");
        px("pre_reset_right", 780, 300, 1'b1, 1, 580);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_async", {bus.frame_tick, bus.enable, bus.side, bus.address}, 14'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        px("post_reset_static", 30, 3, 1'b1, 0, 80);
        fs("post_reset_latch");
        px("post_reset_s0", 30, 3, 1'b1, 0, 80);
        fs("post_reset_fs1");
        px("post_reset_s1",       30,   3, 1'b1, 0,  79);
        px("post_reset_s1_right", 780, 300, 1'b1, 1, 605);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
